ycbcr_to_rgb565: RTL and testbench

//  Inverse of the camera-path RGB565->YCbCr stage: converts 8-bit full-range BT.601 Y/Cb/Cr pixels to RGB565.

---
 rtl/ycbcr_to_rgb565_pkg.sv | 41 ++++
 rtl/ycbcr_to_rgb565_if.sv | 36 +++
 rtl/ycbcr_to_rgb565_sync_delay.sv | 31 +++
 rtl/ycbcr_to_rgb565.sv | 158 +++++++++++++++
 tb/tb_ycbcr_to_rgb565.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ycbcr_to_rgb565_pkg.sv
// Shared constants and helpers for the YCbCr -> RGB565 conversion path.
// Coefficients are BT.601 full-range values scaled by 256.
package ycbcr_pkg;

    localparam logic signed [17:0] COEF_R_CR  = 18'sd359;
    localparam logic signed [17:0] COEF_G_CB  = 18'sd88;
    localparam logic signed [17:0] COEF_G_CR  = 18'sd183;
    localparam logic signed [17:0] COEF_B_CB  = 18'sd454;
    localparam logic signed [8:0]  CHROMA_OFS = 9'sd128;
    localparam logic signed [19:0] ROUND      = 20'sd128;

    // Pixel and sync pipelines must stay the same length.
    localparam int PIPE_LAT = 32'sd4;

    // Truncate 8-bit components to 5/6/5 and pack as {R,G,B}.
    function automatic logic [15:0] pack_rgb565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
        logic [15:0] rf;
        logic [15:0] gf;
        logic [15:0] bf;
        rf = ({8'h00, r} >> 3'd3) << 4'd11;
        gf = ({8'h00, g} >> 3'd2) << 4'd5;
        bf = {8'h00, b} >> 3'd3;
        return rf | gf | bf;
    endfunction

    // Saturate a scaled-by-256 sum to an 8-bit component, never wrapping.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic [7:0] res;
        if (s < 20'sd0) begin
            res = 8'h00;
        end else if (s > 20'sd65535) begin
            res = 8'hFF;
        end else begin
            res = s[15:8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ycbcr_to_rgb565_if.sv
// Pixel stream bundle: YCbCr pixels with frame syncs in, RGB565 with
// delayed syncs out. The slave side is the converter.
// The per_img_mask signal exists only when MASK_OVERLAY_EN is defined.
interface ycbcr_to_rgb565_if;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [7:0]  per_img_Y;
    logic [7:0]  per_img_Cb;
    logic [7:0]  per_img_Cr;
`ifdef MASK_OVERLAY_EN
    logic        per_img_mask;
`endif
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [15:0] post_img_rgb;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output per_img_Y, per_img_Cb, per_img_Cr,
`ifdef MASK_OVERLAY_EN
        output per_img_mask,
`endif
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_rgb
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        input  per_img_Y, per_img_Cb, per_img_Cr,
`ifdef MASK_OVERLAY_EN
        input  per_img_mask,
`endif
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_rgb
    );
endinterface

// File: rtl/ycbcr_to_rgb565_sync_delay.sv
// Fixed-depth shift register for frame sync bits so they stay aligned
// with the pixel data pipeline. Cleared asynchronously to 0.
module sync_delay #(
    parameter int W     = 32'sd3,
    parameter int DEPTH = 32'sd4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr_r [DEPTH];

    // Shift the sync bits one stage per clock; reset flushes all stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                sr_r[i] <= '0;
            end
        end else begin
            sr_r[0] <= din;
            for (int i = 32'sd1; i < DEPTH; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/ycbcr_to_rgb565.sv
// Full-range BT.601 YCbCr (8/8/8) to RGB565 converter.
// Free-running 4-stage pipeline: offset removal, multiply, sum with
// rounding, clamp and pack. Syncs are delayed by the same 4 clocks.
// Optional build macro: MASK_OVERLAY_EN adds a per-pixel mask input that
// replaces the converted pixel with OVERLAY_COLOR.
module ycbcr_to_rgb565
    import ycbcr_pkg::*;
#(
    parameter logic [15:0] OVERLAY_COLOR = 16'hF800
) (
    input  logic              clk,
    input  logic              rst_n,
    ycbcr_to_rgb565_if.slave  pix
);

`ifdef MASK_OVERLAY_EN
    localparam int SYNC_W = 32'sd4;
`else
    localparam int SYNC_W = 32'sd3;
`endif

    // Stage 1: luma scaled by 256, chroma with offset removed
    logic [15:0]        s1_y256_r;
    logic signed [8:0]  s1_cb_r;
    logic signed [8:0]  s1_cr_r;
    // Stage 2: chroma products
    logic [15:0]        s2_y256_r;
    logic signed [17:0] s2_rc_r;
    logic signed [17:0] s2_gb_r;
    logic signed [17:0] s2_gc_r;
    logic signed [17:0] s2_bc_r;
    // Stage 3: rounded sums, still scaled by 256
    logic signed [19:0] s3_r_r;
    logic signed [19:0] s3_g_r;
    logic signed [19:0] s3_b_r;
    // Stage 4: packed pixel
    logic [15:0]        s4_rgb_r;

    logic signed [8:0]  cb_s;
    logic signed [8:0]  cr_s;
    logic signed [17:0] cb_ext_s;
    logic signed [17:0] cr_ext_s;
    logic signed [19:0] y_ext_s;
    logic signed [19:0] rc_ext_s;
    logic signed [19:0] gb_ext_s;
    logic signed [19:0] gc_ext_s;
    logic signed [19:0] bc_ext_s;
    logic [15:0]        rgb_s;

    logic [SYNC_W-1:0]  sync_in_s;
    logic [SYNC_W-1:0]  sync_out_s;
    logic               vsync_d_s;
    logic               href_d_s;
    logic               clken_d_s;
    logic               mask_d_s;

    // Sign-extend operands so every stage computes at its full signed width.
    always_comb begin
        cb_s     = $signed({1'b0, pix.per_img_Cb}) - CHROMA_OFS;
        cr_s     = $signed({1'b0, pix.per_img_Cr}) - CHROMA_OFS;
        cb_ext_s = $signed({{9{s1_cb_r[8]}}, s1_cb_r});
        cr_ext_s = $signed({{9{s1_cr_r[8]}}, s1_cr_r});
        y_ext_s  = $signed({4'h0, s2_y256_r});
        rc_ext_s = $signed({{2{s2_rc_r[17]}}, s2_rc_r});
        gb_ext_s = $signed({{2{s2_gb_r[17]}}, s2_gb_r});
        gc_ext_s = $signed({{2{s2_gc_r[17]}}, s2_gc_r});
        bc_ext_s = $signed({{2{s2_bc_r[17]}}, s2_bc_r});
    end

    // Stage 1: capture luma as Y*256 and centre the chroma around zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_y256_r <= 16'h0000;
            s1_cb_r   <= 9'sd0;
            s1_cr_r   <= 9'sd0;
        end else begin
            s1_y256_r <= {pix.per_img_Y, 8'h00};
            s1_cb_r   <= cb_s;
            s1_cr_r   <= cr_s;
        end
    end

    // Stage 2: chroma contributions to each colour channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_y256_r <= 16'h0000;
            s2_rc_r   <= 18'sd0;
            s2_gb_r   <= 18'sd0;
            s2_gc_r   <= 18'sd0;
            s2_bc_r   <= 18'sd0;
        end else begin
            s2_y256_r <= s1_y256_r;
            s2_rc_r   <= cr_ext_s * COEF_R_CR;
            s2_gb_r   <= cb_ext_s * COEF_G_CB;
            s2_gc_r   <= cr_ext_s * COEF_G_CR;
            s2_bc_r   <= cb_ext_s * COEF_B_CB;
        end
    end

    // Stage 3: channel sums with half-LSB rounding before the >>8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_r_r <= 20'sd0;
            s3_g_r <= 20'sd0;
            s3_b_r <= 20'sd0;
        end else begin
            s3_r_r <= y_ext_s + rc_ext_s + ROUND;
            s3_g_r <= y_ext_s - gb_ext_s - gc_ext_s + ROUND;
            s3_b_r <= y_ext_s + bc_ext_s + ROUND;
        end
    end

    // Stage 4: saturate each channel and pack to RGB565.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_rgb_r <= 16'h0000;
        end else begin
            s4_rgb_r <= pack_rgb565(clamp8(s3_r_r), clamp8(s3_g_r), clamp8(s3_b_r));
        end
    end

`ifdef MASK_OVERLAY_EN
    assign sync_in_s = {pix.per_frame_vsync, pix.per_frame_href,
                        pix.per_frame_clken, pix.per_img_mask};
    assign {vsync_d_s, href_d_s, clken_d_s, mask_d_s} = sync_out_s;
`else
    assign sync_in_s = {pix.per_frame_vsync, pix.per_frame_href, pix.per_frame_clken};
    assign {vsync_d_s, href_d_s, clken_d_s} = sync_out_s;
    assign mask_d_s  = 1'b0;
`endif

    sync_delay #(
        .W     (SYNC_W),
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sync_in_s),
        .dout  (sync_out_s)
    );

    // Blank outside active lines; masked active pixels take the overlay colour.
    always_comb begin
        if (!href_d_s) begin
            rgb_s = 16'h0000;
        end else if (mask_d_s) begin
            rgb_s = OVERLAY_COLOR;
        end else begin
            rgb_s = s4_rgb_r;
        end
    end

    assign pix.post_frame_vsync = vsync_d_s;
    assign pix.post_frame_href  = href_d_s;
    assign pix.post_frame_clken = clken_d_s;
    assign pix.post_img_rgb     = rgb_s;

endmodule

// File: tb/tb_ycbcr_to_rgb565.sv
// Directed testbench for ycbcr_to_rgb565: conversion vectors with
// hand-computed RGB565 results, sync alignment, blanking and reset.
module tb_ycbcr_to_rgb565;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ycbcr_to_rgb565_if pif();

    ycbcr_to_rgb565 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pif)
    );

    always #5 clk = ~clk;

    // Hand-computed pixel table: Y, Cb, Cr -> RGB565
    logic [7:0]  tab_y   [7] = '{8'd128, 8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd100};
    logic [7:0]  tab_cb  [7] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd255, 8'd0,   8'd150};
    logic [7:0]  tab_cr  [7] = '{8'd128, 8'd128, 8'd128, 8'd255, 8'd255, 8'd0,   8'd90};
    logic [15:0] tab_rgb [7] = '{16'h8410, 16'hFFFF, 16'h0000, 16'hB000, 16'hFBDF, 16'h0440, 16'h2BD1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic c,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        pif.per_frame_vsync = v;
        pif.per_frame_href  = h;
        pif.per_frame_clken = c;
        pif.per_img_Y       = y;
        pif.per_img_Cb      = cb;
        pif.per_img_Cr      = cr;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_cmp++; if (pif.post_frame_vsync !== 1'b0) begin n_bad++; $display("FAIL reset_vsync: got %b want 0", pif.post_frame_vsync); end
        n_cmp++; if (pif.post_frame_href !== 1'b0) begin n_bad++; $display("FAIL reset_href: got %b want 0", pif.post_frame_href); end
        n_cmp++; if (pif.post_frame_clken !== 1'b0) begin n_bad++; $display("FAIL reset_clken: got %b want 0", pif.post_frame_clken); end
        n_cmp++; if (pif.post_img_rgb !== 16'h0000) begin n_bad++; $display("FAIL reset_rgb: got %h want 0000", pif.post_img_rgb); end
        rst_n = 1'b1;
        repeat (2) step();
        n_cmp++; if (pif.post_img_rgb !== 16'h0000) begin n_bad++; $display("FAIL post_release_rgb: got %h want 0000", pif.post_img_rgb); end
    endtask

    task automatic test_latency();
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (2) step();
        n_cmp++; if (pif.post_frame_href !== 1'b0 || pif.post_img_rgb !== 16'h0000) begin
            n_bad++; $display("FAIL latency_early: got href=%b rgb=%h want href=0 rgb=0000", pif.post_frame_href, pif.post_img_rgb);
        end
        step();
        n_cmp++; if (pif.post_img_rgb !== 16'h8410) begin n_bad++; $display("FAIL latency_rgb: got %h want 8410", pif.post_img_rgb); end
        n_cmp++; if (pif.post_frame_href !== 1'b1 || pif.post_frame_clken !== 1'b1) begin
            n_bad++; $display("FAIL latency_sync: got href=%b clken=%b want 1 1", pif.post_frame_href, pif.post_frame_clken);
        end
        step();
        n_cmp++; if (pif.post_img_rgb !== 16'h0000) begin n_bad++; $display("FAIL latency_after: got %h want 0000", pif.post_img_rgb); end
    endtask

    task automatic test_conversion();
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b1, 1'b1, tab_y[k], tab_cb[k], tab_cr[k]);
            repeat (4) step();
            n_cmp++; if (pif.post_img_rgb !== tab_rgb[k]) begin
                n_bad++; $display("FAIL convert_%0d: Y=%0d Cb=%0d Cr=%0d got %h want %h",
                                  k, tab_y[k], tab_cb[k], tab_cr[k], pif.post_img_rgb, tab_rgb[k]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (4) step();
    endtask

    task automatic test_sync_delay();
        logic [3:0] v_seq [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] h_seq [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] c_seq [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int         p_seq [12] = '{1, 4, 6, 0, 3, 6, 1, 5, 4, 1, 4, 0};
        logic [15:0] exp_rgb;
        for (int i = 0; i < 16; i++) begin
            if (i < 12) begin
                drive(v_seq[i][0], h_seq[i][0], c_seq[i][0], tab_y[p_seq[i]], tab_cb[p_seq[i]], tab_cr[p_seq[i]]);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            end
            step();
            if (i >= 3 && i - 3 < 12) begin
                exp_rgb = h_seq[i-3][0] ? tab_rgb[p_seq[i-3]] : 16'h0000;
                n_cmp++; if (pif.post_frame_vsync !== v_seq[i-3][0] || pif.post_frame_href !== h_seq[i-3][0] ||
                             pif.post_frame_clken !== c_seq[i-3][0]) begin
                    n_bad++; $display("FAIL sync_%0d: got v/h/c=%b%b%b want %b%b%b", i - 3,
                                      pif.post_frame_vsync, pif.post_frame_href, pif.post_frame_clken,
                                      v_seq[i-3][0], h_seq[i-3][0], c_seq[i-3][0]);
                end
                n_cmp++; if (pif.post_img_rgb !== exp_rgb) begin
                    n_bad++; $display("FAIL stream_rgb_%0d: got %h want %h", i - 3, pif.post_img_rgb, exp_rgb);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        int cnt;
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        repeat (6) step();
        n_cmp++; if (pif.post_img_rgb !== 16'h8410) begin n_bad++; $display("FAIL midline_pre: got %h want 8410", pif.post_img_rgb); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pif.post_img_rgb !== 16'h0000 || pif.post_frame_href !== 1'b0 ||
                     pif.post_frame_clken !== 1'b0 || pif.post_frame_vsync !== 1'b0) begin
            n_bad++; $display("FAIL midline_reset: got rgb=%h href=%b want rgb=0000 href=0", pif.post_img_rgb, pif.post_frame_href);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (pif.post_img_rgb !== 16'h0000 || pif.post_frame_href !== 1'b0) begin
            n_bad++; $display("FAIL midline_flushed: got rgb=%h href=%b want 0000 0", pif.post_img_rgb, pif.post_frame_href);
        end
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        cnt = 0;
        while (cnt < 10 && pif.post_img_rgb === 16'h0000) begin
            step();
            cnt++;
        end
        n_cmp++; if (cnt !== 4 || pif.post_img_rgb !== 16'h8410) begin
            n_bad++; $display("FAIL midline_resume: got %0d clk rgb=%h want 4 clk rgb=8410", cnt, pif.post_img_rgb);
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (4) step();
    endtask

`ifdef MASK_OVERLAY_EN
    task automatic test_mask();
        pif.per_img_mask = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        repeat (4) step();
        n_cmp++; if (pif.post_img_rgb !== 16'hF800) begin n_bad++; $display("FAIL mask_overlay: got %h want F800", pif.post_img_rgb); end
        drive(1'b0, 1'b0, 1'b1, 8'd128, 8'd128, 8'd128);
        repeat (4) step();
        n_cmp++; if (pif.post_img_rgb !== 16'h0000) begin n_bad++; $display("FAIL mask_blank: got %h want 0000", pif.post_img_rgb); end
        pif.per_img_mask = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        repeat (4) step();
        n_cmp++; if (pif.post_img_rgb !== 16'h8410) begin n_bad++; $display("FAIL mask_off: got %h want 8410", pif.post_img_rgb); end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (4) step();
    endtask
`endif

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
`ifdef MASK_OVERLAY_EN
        pif.per_img_mask = 1'b0;
`endif
        test_reset();
        test_latency();
        test_conversion();
        test_sync_delay();
        test_reset_midline();
`ifdef MASK_OVERLAY_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
